gray_wptr_gen: RTL and testbench

- Write-side pointer generator for an async FIFO; it is the binary-to-Gray encoder counterpart of the team's Gray-to-binary decoder.
- Keeps a binary write pointer and publishes it as a registered Gray pointer, so the read domain can synchronise it safely.
- Computes full, almost_full and fill level against a read pointer that has already been synchronised into this domain as Gray code.
- Sits between the write-side user logic and the FIFO RAM write port / CDC synchroniser.

---
 rtl/fifo_ptr_pkg.sv | 27 ++
 rtl/gray_wptr_gen_if.sv | 28 ++
 rtl/gray_to_bin_n.sv | 18 +
 rtl/gray_wptr_gen.sv | 66 ++++++
 tb/tb_gray_wptr_gen.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/fifo_ptr_pkg.sv
// Pointer helpers shared by the write- and read-side async FIFO pointer generators.
// Functions work on zero-extended vectors; callers truncate to their pointer width.
package fifo_ptr_pkg;

    localparam int unsigned MAX_PTR_W = 32;

    typedef logic [MAX_PTR_W-1:0] ptr_t;

    // One extra bit beyond the address distinguishes full from empty.
    function automatic int unsigned PTR_W(input int unsigned addr_w);
        return addr_w + 1;
    endfunction

    function automatic ptr_t bin2gray(input ptr_t b);
        return (b >> 1) ^ b;
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
        for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_wptr_gen_if.sv
// Write-side pointer bundle between user logic / RAM / CDC and the Gray pointer generator.
interface gray_wptr_gen_if #(
    parameter int unsigned ADDR_W = 4
);
    import fifo_ptr_pkg::*;

    localparam int unsigned PW = PTR_W(ADDR_W);

    logic              inc;
    logic [PW-1:0]     rgray_sync;
    logic [ADDR_W-1:0] waddr;
    logic [PW-1:0]     wgray;
    logic              full;
    logic              almost_full;
    logic [PW-1:0]     wlevel;
    logic              overflow;

    modport master (
        input  inc, rgray_sync,
        output waddr, wgray, full, almost_full, wlevel, overflow
    );

    modport slave (
        output inc, rgray_sync,
        input  waddr, wgray, full, almost_full, wlevel, overflow
    );

endinterface

// File: rtl/gray_to_bin_n.sv
// Combinational N-bit Gray-to-binary decoder (XOR prefix from the MSB down).
module gray_to_bin_n
    import fifo_ptr_pkg::*;
#(
    parameter int unsigned N = 5
) (
    input  logic [N-1:0] gray,
    output logic [N-1:0] bin
);

    ptr_t gray_ext;
    ptr_t bin_ext;

    assign gray_ext = ptr_t'(gray);
    assign bin_ext  = gray2bin(gray_ext);
    assign bin      = bin_ext[N-1:0];

endmodule

// File: rtl/gray_wptr_gen.sv
// Async FIFO write pointer: binary counter published as a registered Gray pointer,
// with full / almost_full / level computed against the synchronised read pointer.
module gray_wptr_gen
    import fifo_ptr_pkg::*;
#(
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned AF_LEVEL = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gray_wptr_gen_if.master       bus
);

    localparam int unsigned       PW     = PTR_W(ADDR_W);
    localparam logic [PW-1:0]     AF_LVL = PW'(AF_LEVEL);

    logic [PW-1:0] wbin_q, wgray_q, wlevel_q;
    logic          full_q, almost_full_q, overflow_q;

    logic          accepted;
    logic [PW-1:0] bnext, gnext, rbin, wlevel_d, rgray_full;
    logic          full_d, almost_full_d;

    gray_to_bin_n #(
        .N (PW)
    ) u_rptr_dec (
        .gray (bus.rgray_sync),
        .bin  (rbin)
    );

    assign accepted = bus.inc & ~full_q;
    assign bnext    = wbin_q + PW'(accepted);
    assign gnext    = (bnext >> 1) ^ bnext;

    // Full when the writer is exactly one lap ahead: top two Gray bits inverted, rest equal.
    assign rgray_full    = {~bus.rgray_sync[PW-1:PW-2], bus.rgray_sync[PW-3:0]};
    assign full_d        = (gnext == rgray_full);
    assign wlevel_d      = bnext - rbin;
    assign almost_full_d = (wlevel_d >= AF_LVL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin_q        <= '0;
            wgray_q       <= '0;
            wlevel_q      <= '0;
            full_q        <= 1'b0;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            wbin_q        <= bnext;
            wgray_q       <= gnext;
            wlevel_q      <= wlevel_d;
            full_q        <= full_d;
            almost_full_q <= almost_full_d;
            overflow_q    <= bus.inc & full_q;
        end
    end

    assign bus.waddr       = wbin_q[ADDR_W-1:0];
    assign bus.wgray       = wgray_q;
    assign bus.full        = full_q;
    assign bus.almost_full = almost_full_q;
    assign bus.wlevel      = wlevel_q;
    assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_gray_wptr_gen.sv
// Directed bench for gray_wptr_gen: reset, fill, overflow, drain, wrap and mid-op reset.
module tb_gray_wptr_gen;

    localparam int unsigned ADDR_W = 4;

    // Gray codes of 0..31, written out by hand.
    localparam logic [4:0] GTAB [32] = '{
        5'h00, 5'h01, 5'h03, 5'h02, 5'h06, 5'h07, 5'h05, 5'h04,
        5'h0C, 5'h0D, 5'h0F, 5'h0E, 5'h0A, 5'h0B, 5'h09, 5'h08,
        5'h18, 5'h19, 5'h1B, 5'h1A, 5'h1E, 5'h1F, 5'h1D, 5'h1C,
        5'h14, 5'h15, 5'h17, 5'h16, 5'h12, 5'h13, 5'h11, 5'h10
    };

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    gray_wptr_gen_if #(.ADDR_W(ADDR_W)) bus ();

    gray_wptr_gen #(
        .ADDR_W   (ADDR_W),
        .AF_LEVEL (12)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wgray"}, 32'(bus.wgray), 32'h0);
        chk({tag, "_waddr"}, 32'(bus.waddr), 32'h0);
        chk({tag, "_full"}, 32'(bus.full), 32'h0);
        chk({tag, "_af"}, 32'(bus.almost_full), 32'h0);
        chk({tag, "_wlevel"}, 32'(bus.wlevel), 32'h0);
        chk({tag, "_ovf"}, 32'(bus.overflow), 32'h0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] prev;
        bus.inc        = 1'b0;
        bus.rgray_sync = '0;

        // 1. Asynchronous reset, asserted before any clock edge
        #1 rst_n = 1'b0;
        #1 chk_zero("rst_async");
        for (int i = 0; i < 3; i++) begin
            bus.inc = 1'($urandom_range(0, 1));
            tick();
            chk_zero("rst_hold");
        end
        rst_n   = 1'b1;
        bus.inc = 1'b1;
        tick();
        chk("rst_first_wgray", 32'(bus.wgray), 32'h01);
        chk("rst_first_waddr", 32'(bus.waddr), 32'h1);
        bus.inc = 1'b0;

        // 2. Fill from empty
        pulse_reset();
        bus.rgray_sync = 5'h00;
        bus.inc        = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk($sformatf("fill%0d_wgray", i), 32'(bus.wgray), 32'(GTAB[i]));
            chk($sformatf("fill%0d_waddr", i), 32'(bus.waddr), 32'(i % 16));
            chk($sformatf("fill%0d_wlevel", i), 32'(bus.wlevel), 32'(i));
            chk($sformatf("fill%0d_af", i), 32'(bus.almost_full), (i >= 12) ? 32'h1 : 32'h0);
            chk($sformatf("fill%0d_full", i), 32'(bus.full), (i == 16) ? 32'h1 : 32'h0);
        end

        // 3. Overflow: inc held while full
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ovf_pulse", 32'(bus.overflow), 32'h1);
            chk("ovf_wgray", 32'(bus.wgray), 32'h18);
            chk("ovf_waddr", 32'(bus.waddr), 32'h0);
            chk("ovf_full", 32'(bus.full), 32'h1);
        end
        bus.inc = 1'b0;
        tick();
        chk("ovf_clear", 32'(bus.overflow), 32'h0);

        // 4. Drain one slot
        bus.rgray_sync = 5'h01;
        tick();
        chk("drain_full", 32'(bus.full), 32'h0);
        chk("drain_wlevel", 32'(bus.wlevel), 32'd15);
        chk("drain_af", 32'(bus.almost_full), 32'h1);
        bus.inc = 1'b1;
        tick();
        chk("drain_wgray", 32'(bus.wgray), 32'h19);
        chk("drain_refull", 32'(bus.full), 32'h1);
        chk("drain_wlevel16", 32'(bus.wlevel), 32'd16);
        bus.inc = 1'b0;

        // 5. Wrap with the reader one step behind
        pulse_reset();
        prev = 5'h00;
        bus.inc = 1'b1;
        for (int i = 0; i < 32; i++) begin
            bus.rgray_sync = GTAB[i];
            tick();
            chk($sformatf("wrap%0d_wgray", i), 32'(bus.wgray), 32'(GTAB[(i + 1) % 32]));
            chk($sformatf("wrap%0d_hd", i), 32'($countones(bus.wgray ^ prev)), 32'd1);
            chk($sformatf("wrap%0d_wlevel", i), 32'(bus.wlevel), 32'd1);
            chk($sformatf("wrap%0d_full", i), 32'(bus.full), 32'h0);
            prev = bus.wgray;
        end
        bus.inc = 1'b0;
        chk("wrap_end_waddr", 32'(bus.waddr), 32'h0);

        // 6. Reset in the middle of a cycle after 7 writes
        pulse_reset();
        bus.rgray_sync = 5'h00;
        bus.inc = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        bus.inc = 1'b0;
        chk("mid_pre_wgray", 32'(bus.wgray), 32'h04);
        chk("mid_pre_wlevel", 32'(bus.wlevel), 32'd7);
        #2 rst_n = 1'b0;
        #1 chk_zero("mid_rst");
        rst_n   = 1'b1;
        bus.inc = 1'b1;
        tick();
        chk("mid_resume_wgray", 32'(bus.wgray), 32'h01);
        chk("mid_resume_waddr", 32'(bus.waddr), 32'h1);
        bus.inc = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
